// File: rtl/product_accumulator_pkg.sv
// Shared types and constants for the product accumulator: FSM states,
// default operand/guard widths, accumulator width and term-count limit.
package product_accumulator_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_HOLD
    } state_t;

    localparam int N_DEFAULT     = 32;
    localparam int G_DEFAULT     = 8;
    localparam int ACC_W_DEFAULT = 2 * N_DEFAULT + G_DEFAULT;

    localparam int             CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

    function automatic int acc_width(input int n, input int g);
        return 2 * n + g;
    endfunction

endpackage

// File: rtl/product_accumulator_sat_adder.sv
// W-bit signed adder that clamps to the W-bit two's-complement range.
// Purely combinational; clamp_o flags that the true sum was out of range.
module sat_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         clamp_o
);

    logic [W:0] full_sum;

    // One extra bit holds the exact sum; top two bits differing means out of range.
    assign full_sum = {a_i[W-1], a_i} + {b_i[W-1], b_i};
    assign clamp_o  = full_sum[W] ^ full_sum[W-1];

    always_comb begin
        sum_o = full_sum[W-1:0];
        if (clamp_o) begin
            sum_o = full_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/product_accumulator.sv
// Saturating accumulator of signed multiplier products; result presented one
// cycle after the last beat and held (in_ready low) until out_ready or clear.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int G = G_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*N-1:0]       product,
    input  logic                 overflow,
    input  logic                 in_last,
    input  logic                 clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*N+G-1:0]     acc_out,
    output logic [CNT_W-1:0]     term_count,
    output logic                 sat,
    output logic                 ovf
);

    localparam int ACC_W = acc_width(N, G);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   acc_base;
    logic [ACC_W-1:0]   sum;
    logic               clamp;
    logic               accept;

    assign prod_ext = ACC_W'($signed(product));
    assign acc_base = (state_q == S_IDLE) ? '0 : acc_q;

    sat_adder #(.W(ACC_W)) u_sat_adder (
        .a_i     (acc_base),
        .b_i     (prod_ext),
        .sum_o   (sum),
        .clamp_o (clamp)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        ovf_d     = ovf_q;
        // Ready drops combinationally with clear and reset so a beat is never taken then.
        in_ready  = rst_n && !clear && (state_q != S_HOLD);
        out_valid = (state_q == S_HOLD);
        accept    = in_valid && in_ready;

        if (clear) begin
            state_d = S_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_ACCUM: begin
                    if (accept) begin
                        acc_d   = sum;
                        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
                        sat_d   = sat_q | clamp;
                        ovf_d   = ovf_q | overflow;
                        state_d = in_last ? S_HOLD : S_ACCUM;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                        sat_d   = 1'b0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            ovf_q   <= ovf_d;
        end
    end

    assign acc_out    = acc_q;
    assign term_count = cnt_q;
    assign sat        = sat_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a default-width instance and an 8-bit
// instance, checked every cycle against an arithmetic model plus literal values.
module tb_product_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid  [2];
    logic        in_last   [2];
    logic        overflow  [2];
    logic        clear     [2];
    logic        out_ready [2];
    logic [63:0] prod      [2];

    logic        dut_rdy [2];
    logic        dut_vld [2];
    logic        dut_sat [2];
    logic        dut_ovf [2];
    logic [7:0]  dut_cnt [2];
    logic [71:0] acc0;
    logic [7:0]  acc1;

    int n_checks = 0;
    int n_errors = 0;

    product_accumulator u_big (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid[0]),
        .in_ready   (dut_rdy[0]),
        .product    (prod[0]),
        .overflow   (overflow[0]),
        .in_last    (in_last[0]),
        .clear      (clear[0]),
        .out_valid  (dut_vld[0]),
        .out_ready  (out_ready[0]),
        .acc_out    (acc0),
        .term_count (dut_cnt[0]),
        .sat        (dut_sat[0]),
        .ovf        (dut_ovf[0])
    );

    product_accumulator #(.N(4), .G(0)) u_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid[1]),
        .in_ready   (dut_rdy[1]),
        .product    (prod[1][7:0]),
        .overflow   (overflow[1]),
        .in_last    (in_last[1]),
        .clear      (clear[1]),
        .out_valid  (dut_vld[1]),
        .out_ready  (out_ready[1]),
        .acc_out    (acc1),
        .term_count (dut_cnt[1]),
        .sat        (dut_sat[1]),
        .ovf        (dut_ovf[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: exact sums in 128-bit arithmetic, clamped to each instance's range.
    logic signed [127:0] m_acc  [2];
    int                  m_cnt  [2];
    logic                m_sat  [2];
    logic                m_ovf  [2];
    logic                m_hold [2];
    logic                m_started = 1'b0;

    function automatic int accw(input int i);
        return (i == 0) ? 72 : 8;
    endfunction

    function automatic logic signed [127:0] sext(input int i);
        if (i == 0) return 128'($signed(prod[0]));
        return 128'($signed(prod[1][7:0]));
    endfunction

    task automatic model_empty(input int i);
        m_acc[i]  = '0;
        m_cnt[i]  = 0;
        m_sat[i]  = 1'b0;
        m_ovf[i]  = 1'b0;
        m_hold[i] = 1'b0;
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic signed [127:0] s, hi, lo;
            hi = (128'sd1 <<< (accw(i) - 1)) - 128'sd1;
            lo = -(128'sd1 <<< (accw(i) - 1));
            if (!rst_n) begin
                model_empty(i);
                m_started = 1'b1;
            end else if (clear[i]) begin
                model_empty(i);
            end else if (m_hold[i]) begin
                if (out_ready[i]) model_empty(i);
            end else if (in_valid[i]) begin
                s = m_acc[i] + sext(i);
                if (s > hi) begin
                    s = hi;
                    m_sat[i] = 1'b1;
                end else if (s < lo) begin
                    s = lo;
                    m_sat[i] = 1'b1;
                end
                m_acc[i] = s;
                if (m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
                m_ovf[i] = m_ovf[i] | overflow[i];
                if (in_last[i]) m_hold[i] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            for (int i = 0; i < 2; i++) begin
                logic [127:0] act_acc, exp_acc;
                act_acc = (i == 0) ? 128'(acc0) : 128'(acc1);
                exp_acc = (i == 0) ? 128'(m_acc[0][71:0]) : 128'(m_acc[1][7:0]);
                check($sformatf("in_ready%0d", i), 128'(dut_rdy[i]),
                      128'(rst_n && !clear[i] && !m_hold[i]));
                check($sformatf("out_valid%0d", i), 128'(dut_vld[i]), 128'(m_hold[i]));
                check($sformatf("acc_out%0d", i), act_acc, exp_acc);
                check($sformatf("term_count%0d", i), 128'(dut_cnt[i]), 128'(m_cnt[i]));
                check($sformatf("sat%0d", i), 128'(dut_sat[i]), 128'(m_sat[i]));
                check($sformatf("ovf%0d", i), 128'(dut_ovf[i]), 128'(m_ovf[i]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int i, input logic [63:0] p, input logic last, input logic ov);
        in_valid[i] = 1'b1;
        prod[i]     = p;
        in_last[i]  = last;
        overflow[i] = ov;
        tick();
        in_valid[i] = 1'b0;
        in_last[i]  = 1'b0;
        overflow[i] = 1'b0;
    endtask

    task automatic release_result(input int i);
        out_ready[i] = 1'b1;
        tick();
        out_ready[i] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; in_last[i] = 1'b0; overflow[i] = 1'b0;
            clear[i] = 1'b0; out_ready[i] = 1'b0; prod[i] = '0;
        end
        tick();
        tick();
        check("reset_acc", 128'(acc0), 128'(0));
        check("reset_vld", 128'(dut_vld[0]), 128'(0));
        check("reset_rdy", 128'(dut_rdy[0]), 128'(0));
        rst_n = 1'b1;
        #1;
        check("release_rdy", 128'(dut_rdy[0]), 128'(1));

        // Single beat
        beat(0, 64'd2614916801295, 1'b1, 1'b0);
        check("single_vld", 128'(dut_vld[0]), 128'(1));
        check("single_acc", 128'(acc0), 128'(72'd2614916801295));
        check("single_cnt", 128'(dut_cnt[0]), 128'(1));
        check("single_sat_ovf", 128'({dut_sat[0], dut_ovf[0]}), 128'(0));
        release_result(0);
        check("released_vld", 128'(dut_vld[0]), 128'(0));

        // Mixed signs, then back-pressure
        beat(0, 64'd1165763863, 1'b0, 1'b0);
        beat(0, -64'sd2008, 1'b0, 1'b0);
        beat(0, -64'sd263875, 1'b1, 1'b0);
        check("mixed_acc", 128'(acc0), 128'(72'd1165497980));
        check("mixed_cnt", 128'(dut_cnt[0]), 128'(3));
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_acc", 128'(acc0), 128'(72'd1165497980));
            check("bp_rdy", 128'(dut_rdy[0]), 128'(0));
        end
        release_result(0);
        check("bp_idle_rdy", 128'(dut_rdy[0]), 128'(1));
        beat(0, 64'd5, 1'b1, 1'b0);
        check("fresh_acc", 128'(acc0), 128'(5));
        check("fresh_cnt", 128'(dut_cnt[0]), 128'(1));
        release_result(0);

        // Saturation on the 8-bit instance
        beat(1, 64'd100, 1'b0, 1'b0);
        beat(1, 64'd100, 1'b1, 1'b0);
        check("sat_pos_acc", 128'(acc1), 128'(8'h7F));
        check("sat_pos_flag", 128'(dut_sat[1]), 128'(1));
        release_result(1);
        beat(1, -64'sd100, 1'b0, 1'b0);
        check("sat_clean_acc", 128'(acc1), 128'(8'h9C));
        check("sat_clean_flag", 128'(dut_sat[1]), 128'(0));
        beat(1, -64'sd100, 1'b1, 1'b0);
        check("sat_neg_acc", 128'(acc1), 128'(8'h80));
        check("sat_neg_flag", 128'(dut_sat[1]), 128'(1));
        release_result(1);

        // Term count saturates at 255
        for (int k = 0; k < 299; k++) beat(1, 64'd0, 1'b0, 1'b0);
        beat(1, 64'd1, 1'b1, 1'b0);
        check("cnt_sat", 128'(dut_cnt[1]), 128'(255));
        release_result(1);

        // Overflow stickiness and clean restart
        beat(0, 64'd7, 1'b0, 1'b1);
        beat(0, 64'd1, 1'b1, 1'b0);
        check("ovf_flag", 128'(dut_ovf[0]), 128'(1));
        check("ovf_acc", 128'(acc0), 128'(8));
        release_result(0);
        beat(0, 64'd2, 1'b1, 1'b0);
        check("ovf_cleared", 128'(dut_ovf[0]), 128'(0));
        release_result(0);

        // Clear in ACCUM with a simultaneous beat
        beat(0, 64'd10, 1'b0, 1'b0);
        clear[0] = 1'b1; in_valid[0] = 1'b1; prod[0] = 64'd99; in_last[0] = 1'b1;
        #1;
        check("clear_rdy", 128'(dut_rdy[0]), 128'(0));
        tick();
        clear[0] = 1'b0; in_valid[0] = 1'b0; in_last[0] = 1'b0;
        check("clear_accum_vld", 128'(dut_vld[0]), 128'(0));
        check("clear_accum_acc", 128'(acc0), 128'(0));
        check("clear_accum_cnt", 128'(dut_cnt[0]), 128'(0));

        // Clear in HOLD
        beat(0, 64'd3, 1'b1, 1'b0);
        clear[0] = 1'b1;
        tick();
        clear[0] = 1'b0;
        check("clear_hold_vld", 128'(dut_vld[0]), 128'(0));
        check("clear_hold_acc", 128'(acc0), 128'(0));

        // Reset mid-sum (big) and in HOLD (small), with clear also asserted
        beat(0, 64'd12345, 1'b0, 1'b1);
        beat(1, 64'd9, 1'b1, 1'b0);
        rst_n = 1'b0; clear[0] = 1'b1;
        tick();
        check("rst_acc", 128'(acc0), 128'(0));
        check("rst_cnt_ovf", 128'({dut_cnt[0], dut_ovf[0]}), 128'(0));
        check("rst_small", 128'({acc1, dut_vld[1], dut_cnt[1]}), 128'(0));
        check("rst_rdy", 128'(dut_rdy[0]), 128'(0));
        rst_n = 1'b1; clear[0] = 1'b0;
        tick();
        check("post_rst_rdy", 128'(dut_rdy[0]), 128'(1));
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the operand width of the upstream multiplier.
REQ-002 The block SHALL have parameter G, default 8, giving the guard bits; ACC_W = 2N+G.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  product beat offered.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 product  input  2N  signed two's-complement multiplier product.
REQ-008 overflow  input  1  multiplier overflow flag qualifying product.
REQ-009 in_last  input  1  beat is the final term of the current sum.
REQ-010 clear  input  1  abandon current sum and any held result.
REQ-011 out_valid  output  1  result held and valid.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 acc_out  output  ACC_W  signed accumulated sum.
REQ-014 term_count  output  8  beats accepted into this sum.
REQ-015 sat  output  1  sticky: sum was clamped at least once.
REQ-016 ovf  output  1  sticky OR of overflow over accepted beats.

Function
REQ-017 A beat SHALL be accepted exactly when in_valid and in_ready are both high at a rising edge.
REQ-018 States SHALL be IDLE (empty), ACCUM (partial sum) and HOLD (result presented).
REQ-019 in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD; out_valid SHALL be 1 only in HOLD.
REQ-020 On acceptance, acc SHALL become sat(acc + sign-extended product), computed at ACC_W+1 bits, with acc taken as 0 when in IDLE.
REQ-021 Clamping SHALL use limits 2^(ACC_W-1)-1 and -2^(ACC_W-1); any clamp SHALL set sat, which remains set until the next sum starts.
REQ-022 term_count SHALL increment per accepted beat and SHALL saturate at 255 without wrapping.
REQ-023 Transitions: IDLE -> ACCUM on an accepted beat with in_last=0; IDLE/ACCUM -> HOLD on an accepted beat with in_last=1; ACCUM stays on non-last beats; HOLD -> IDLE when out_valid and out_ready are both high.
REQ-024 out_valid SHALL rise the cycle after the in_last beat is accepted (latency 1), and the outputs SHALL stay stable while out_ready is low.
REQ-025 Entering IDLE SHALL zero acc, term_count, sat and ovf, so the first beat of a new sum starts clean.
REQ-026 clear=1 SHALL force IDLE next cycle from any state, discarding a held result; a beat presented in the same cycle SHALL be dropped, and in_ready SHALL be 0 while clear=1.
REQ-027 When in_valid=0 in ACCUM, the block SHALL hold its state indefinitely.

Reset
REQ-028 While rst_n=0 at a rising edge, the block SHALL go to IDLE with acc_out=0, term_count=0, sat=0, ovf=0 and out_valid=0; reset has priority over clear.
REQ-029 in_ready SHALL read 0 during reset cycles and 1 from the first cycle after release.
REQ-030 Reset asserted mid-sum or in HOLD SHALL discard all state with no residual output.

Structure
REQ-031 A shared package SHALL hold the state enum, the default N/G values, and the ACC_W and count-limit constants.
REQ-032 One sub-module, sat_adder (ACC_W-wide signed add with clamp and clamp flag), SHALL be instantiated once; the FSM and registers live in the top module.

Verification
REQ-033 Single beat: product=2614916801295, in_last=1 -> out_valid next cycle, acc_out=2614916801295, term_count=1, sat=0, ovf=0.
REQ-034 Mixed signs: beats 1165763863, -2008, -263875 (last) -> acc_out=1165497980, term_count=3.
REQ-035 Back-pressure: hold out_ready=0 for 5 cycles in HOLD -> outputs stable and in_ready=0; out_ready=1 -> IDLE next cycle, and a new beat is accepted the following cycle with acc starting from 0.
REQ-036 Saturation: with N=4, G=0 (ACC_W=8), beats 100, 100 (last) -> acc_out=127, sat=1; beats -100, -100 -> acc_out=-128, sat=1.
REQ-037 Overflow/clear/reset: beat with overflow=1 then last -> ovf=1; asserting clear in ACCUM or HOLD -> IDLE next cycle, out_valid=0, and a simultaneous beat is ignored; rst_n=0 mid-sum -> all outputs 0.
